// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-SRAM arbiter.
package dmem_pkg;

   typedef enum logic {
      IDLE    = 1'b0,
      RD_WAIT = 1'b1
   } state_t;

   localparam int REQ_CPU    = 0;
   localparam int REQ_LDR    = 1;
   localparam int DEF_ADDR_W = 7;
   localparam int DEF_DATA_W = 32;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin grant generator; on a conflict the requester not granted last wins.
module rr_arb2
   import dmem_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       en_i,
   input  logic [1:0] req_i,
   output logic [1:0] gnt_o
);

   // last_q = 1 means the loader was granted last
   logic last_q, last_d;

   always_comb begin
      gnt_o  = 2'b00;
      last_d = last_q;
      if (en_i) begin
         if (req_i[REQ_CPU] && req_i[REQ_LDR]) begin
            if (last_q) gnt_o[REQ_CPU] = 1'b1;
            else        gnt_o[REQ_LDR] = 1'b1;
         end else begin
            gnt_o = req_i;
         end
      end
      if (gnt_o != 2'b00) last_d = gnt_o[REQ_LDR];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) last_q <= 1'b1;
      else      last_q <= last_d;
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data SRAM between the CPU (m0) and loader (m1) ports,
// drives registered SRAM pins and returns a read-valid strobe after RD_LAT.
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_req_i,
   input  logic              m0_we_i,
   input  logic [ADDR_W-1:0] m0_addr_i,
   input  logic [DATA_W-1:0] m0_wdata_i,
   output logic              m0_gnt_o,
   output logic              m0_rvalid_o,
   output logic [DATA_W-1:0] m0_rdata_o,
   input  logic              m1_req_i,
   input  logic              m1_we_i,
   input  logic [ADDR_W-1:0] m1_addr_i,
   input  logic [DATA_W-1:0] m1_wdata_i,
   output logic              m1_gnt_o,
   output logic              m1_rvalid_o,
   output logic [DATA_W-1:0] m1_rdata_o,
   output logic              sram_cen_n_o,
   output logic              sram_wen_n_o,
   output logic              sram_oen_n_o,
   output logic [ADDR_W-1:0] sram_a_o,
   output logic [DATA_W-1:0] sram_d_o,
   input  logic [DATA_W-1:0] sram_q_i
);

   localparam int CNT_W = 2;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              owner_q, owner_d;
   logic              cen_n_q, cen_n_d;
   logic              wen_n_q, wen_n_d;
   logic [ADDR_W-1:0] a_q, a_d;
   logic [DATA_W-1:0] d_q, d_d;
   logic [1:0]        rvalid_q, rvalid_d;
   logic [1:0]        req, gnt;
   logic              arb_en, win, win_we;

   assign req    = {m1_req_i, m0_req_i};
   // gnt is combinational, so it is also masked while reset is held
   assign arb_en = (state_q == IDLE) && rst;

   rr_arb2 u_arb (
      .clk   (clk),
      .rst   (rst),
      .en_i  (arb_en),
      .req_i (req),
      .gnt_o (gnt)
   );

   assign win    = gnt[REQ_LDR];
   assign win_we = win ? m1_we_i : m0_we_i;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      owner_d  = owner_q;
      cen_n_d  = 1'b1;
      wen_n_d  = 1'b1;
      a_d      = a_q;
      d_d      = d_q;
      rvalid_d = 2'b00;
      case (state_q)
         IDLE: begin
            if (gnt != 2'b00) begin
               cen_n_d = 1'b0;
               wen_n_d = ~win_we;
               a_d     = win ? m1_addr_i  : m0_addr_i;
               d_d     = win ? m1_wdata_i : m0_wdata_i;
               if (!win_we) begin
                  state_d = RD_WAIT;
                  cnt_d   = CNT_W'(RD_LAT);
                  owner_d = win;
               end
            end
         end
         RD_WAIT: begin
            cnt_d = cnt_q - CNT_W'(1);
            // last wait cycle: data lands on sram_q next cycle with the strobe
            if (cnt_q == CNT_W'(1)) begin
               state_d           = IDLE;
               rvalid_d[owner_q] = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         owner_q  <= 1'b0;
         cen_n_q  <= 1'b1;
         wen_n_q  <= 1'b1;
         a_q      <= '0;
         d_q      <= '0;
         rvalid_q <= 2'b00;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         owner_q  <= owner_d;
         cen_n_q  <= cen_n_d;
         wen_n_q  <= wen_n_d;
         a_q      <= a_d;
         d_q      <= d_d;
         rvalid_q <= rvalid_d;
      end
   end

   assign m0_gnt_o     = gnt[REQ_CPU];
   assign m1_gnt_o     = gnt[REQ_LDR];
   assign m0_rvalid_o  = rvalid_q[REQ_CPU];
   assign m1_rvalid_o  = rvalid_q[REQ_LDR];
   assign m0_rdata_o   = sram_q_i;
   assign m1_rdata_o   = sram_q_i;
   assign sram_cen_n_o = cen_n_q;
   assign sram_wen_n_o = wen_n_q;
   assign sram_oen_n_o = 1'b0;
   assign sram_a_o     = a_q;
   assign sram_d_o     = d_q;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer for the single-port 128x32 data SRAM used by the single-cycle MIPS core. It shares the SRAM between the CPU load/store port (m0) and a loader/debug port (m1) using a round-robin request/grant handshake. It drives the SRAM's active-low CEN/WEN/OEN pins from registers and tracks read latency, so each requester sees a clean response strobe.

## Interface
- ADDR_W, 7, word-address width (SRAM depth 2**ADDR_W)
- DATA_W, 32, data width
- RD_LAT, 1, SRAM read latency in cycles; legal range 1..3
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- m0_req / m1_req  in  1  access request; held high with fields stable until granted
- m0_we / m1_we  in  1  1 = write, 0 = read
- m0_addr / m1_addr  in  ADDR_W  word address; CPU supplies byte_addr[8:2]
- m0_wdata / m1_wdata  in  DATA_W  write data
- m0_gnt / m1_gnt  out  1  one-cycle grant; the request is consumed in this cycle
- m0_rvalid / m1_rvalid  out  1  one-cycle read-data-valid strobe
- m0_rdata / m1_rdata  out  DATA_W  both driven from sram_q; meaningful only while the matching rvalid is high
- sram_cen_n  out  1  chip enable, active-low
- sram_wen_n  out  1  write enable, active-low (0 = write)
- sram_oen_n  out  1  output enable, constant 0
- sram_a  out  ADDR_W  SRAM address
- sram_d  out  DATA_W  SRAM write data
- sram_q  in  DATA_W  SRAM read data

## Operation
- FSM has two states: IDLE and RD_WAIT.
- IDLE:
  - Grants are issued only in IDLE. Grant logic is combinational from the reqs and the round-robin pointer.
  - If one req is high, that requester is granted.
  - If both reqs are high, the requester not granted last wins.
  - The pointer updates only on a grant. After reset the pointer is "last = m1", so m0 wins the first conflict.
- On a grant, the winner's addr, wdata and we are registered onto sram_a, sram_d and sram_wen_n, and sram_cen_n is driven low for exactly the next cycle.
- Write grant: the FSM stays in IDLE, so back-to-back writes can be granted every cycle.
- Read grant:
  - Load the latency counter with RD_LAT, latch the owner id, and enter RD_WAIT.
  - RD_WAIT decrements the counter each cycle. When it expires, the FSM returns to IDLE and the owner's rvalid goes high for one cycle.
- No grant is issued in RD_WAIT, so any pending req simply waits.
- sram_cen_n is 1 in every cycle without an access. sram_a and sram_d hold their last values.
- Reset state: IDLE, counter 0, pointer = m1, sram_cen_n = 1, sram_wen_n = 1, sram_a = 0, sram_d = 0, both rvalid 0, both gnt 0.
- Reset during RD_WAIT aborts the read: no rvalid is produced and the requester must reissue.
- sram_oen_n is 0 at all times, including reset.

## Timing
- Grant in cycle T; the SRAM access cycle is T+1.
- Read: rvalid is high in cycle T+1+RD_LAT; latency from grant to rvalid is 1+RD_LAT cycles.
- The next grant is allowed in cycle T+1+RD_LAT, the same cycle as rvalid.
- Write throughput is 1 per cycle. Read throughput is 1 per 1+RD_LAT cycles.
- The CPU must stall while its req is high and gnt is low, and for reads until rvalid.
- A req that deasserts before gnt is a protocol violation; behaviour is not defined.

## Structure
- Package dmem_pkg holds:
  - the FSM state type (IDLE, RD_WAIT)
  - the requester index constants (REQ_CPU = 0, REQ_LDR = 1)
  - the default ADDR_W and DATA_W
- Sub-module rr_arb2: a 2-way round-robin grant generator with its own pointer register and a grant-enable input. The top level gates that enable with state == IDLE.
- The top level holds the FSM, latency counter, owner register and SRAM output registers.

## Test plan
- Reset check: hold rst low, toggle the clock, drive random reqs.
  - Required: sram_cen_n = 1, sram_wen_n = 1, sram_a = 0, sram_d = 0, all gnt and rvalid = 0.
- Write then read, RD_LAT = 1:
  - m0 writes 0xDEADBEEF to address 5. Required: gnt at T; in T+1, cen_n = 0, wen_n = 0, a = 5, d = 0xDEADBEEF.
  - m0 then reads address 5. Required: m0_rvalid at grant+2 with m0_rdata = 0xDEADBEEF, and m1_rvalid stays 0.
- Conflict fairness: both request writes continuously for 4 cycles.
  - Required: grants alternate m0, m1, m0, m1, with exactly one gnt per cycle.
- Read blocking: m0 reads; m1 raises a write req one cycle after m0's grant.
  - Required: m1_gnt is held low until cycle T+1+RD_LAT, the same cycle as m0_rvalid.
- RD_LAT = 3 build: m1 reads address 127 after it was written with 0x0000_00A5.
  - Required: m1_rvalid exactly 4 cycles after the grant, data 0x0000_00A5, and no grants in between.
- Reset mid-read: assert rst during RD_WAIT, then release with both requesting.
  - Required: no rvalid is ever produced for the aborted read, and after release m0 is granted first.
